// File: rtl/iir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iir_pkg
// Description : Shared constants for the IIR filter chain. Holds the sample
//               width of the upstream filter output and the default
//               decimation ratio and output FIFO depth.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package iir_pkg;

    localparam int Y_W           = 12;  // filter output sample width
    localparam int DECIM_DEFAULT = 4;   // default decimation ratio
    localparam int DEPTH_DEFAULT = 8;   // default output FIFO depth

    // True when v is a power of two inside [lo, hi]; used for parameter checks.
    function automatic bit pow2_in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi) && ((v & (v - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iir_fifo.sv
`default_nettype none
// ============================================================================
// Module      : iir_fifo
// Description : First-word-fall-through FIFO. The head entry is presented on
//               pop_data whenever the FIFO is non-empty. A push into a full
//               FIFO is accepted only when a pop happens on the same edge.
// Ports       : clk, rst       - clock, asynchronous active-high reset
//               push/push_data - write request and data
//               pop            - read request (ignored while empty)
//               pop_data       - head entry (0 while empty)
//               full, empty    - occupancy flags
//               level          - occupancy 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module iir_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH + 1);

    logic [W-1:0]       r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;

    logic w_rd;
    logic w_wr;

    assign empty = (r_level == '0);
    assign full  = (r_level == c_LVL_W'(DEPTH));
    assign level = r_level;

    // A pop on the same edge frees the slot a full-FIFO push needs.
    assign w_rd = pop && !empty;
    assign w_wr = push && (!full || w_rd);

    assign pop_data = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/iir_decim.sv
`default_nettype none
// ============================================================================
// Module      : iir_decim
// Description : Averaging decimator behind the IIR stage. Sums DECIM accepted
//               samples, emits sum >> log2(DECIM) into an output FWFT FIFO
//               and flags dropped results with a sticky overflow bit.
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               en, y_in            - input sample strobe and data
//               ovf_clr             - clears the sticky overflow flag
//               out_data, out_valid - FIFO head and its valid flag
//               out_ready           - consumer accept
//               level               - FIFO occupancy
//               ovf                 - sticky result-dropped flag
// Revision    : 1.0 - initial release
// ============================================================================
module iir_decim
    import iir_pkg::*;
#(
    parameter int DECIM = DECIM_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [Y_W-1:0]               y_in,
    input  logic                         ovf_clr,
    output logic [Y_W-1:0]               out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         ovf
);

    localparam int c_SHIFT = $clog2(DECIM);
    localparam int c_ACC_W = Y_W + c_SHIFT;

    logic [1:0]         r_sync;
    logic [c_ACC_W-1:0] r_acc;
    logic [c_SHIFT-1:0] r_phase;

    logic               w_take;
    logic               w_last;
    logic [c_ACC_W-1:0] w_sum;
    logic [Y_W-1:0]     w_result;
    logic               w_push;
    logic               w_full;
    logic               w_empty;
    logic               w_drop;

    // Reset release passes through two flops before sampling is enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    assign w_take   = en && r_sync[1];
    assign w_last   = (r_phase == c_SHIFT'(DECIM - 1));
    // The accumulator is wide enough that DECIM full-scale samples never wrap.
    assign w_sum    = r_acc + c_ACC_W'(y_in);
    assign w_result = w_sum[c_ACC_W-1:c_SHIFT];
    assign w_push   = w_take && w_last;
    assign w_drop   = w_push && w_full && !(out_ready && !w_empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_phase <= '0;
        end else if (w_take) begin
            r_phase <= r_phase + 1'b1;
            r_acc   <= w_last ? '0 : w_sum;
        end
    end

    // A drop on the same edge as a clear leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (w_drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    iir_fifo #(
        .W     (Y_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_result),
        .pop       (out_ready),
        .pop_data  (out_data),
        .full      (w_full),
        .empty     (w_empty),
        .level     (level)
    );

    assign out_valid = !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_iir_decim.sv
`default_nettype none
// ============================================================================
// Module      : tb_iir_decim
// Description : Self-checking bench for iir_decim with a queue-based
//               reference model (sample window + output FIFO queue).
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iir_decim;

    localparam int DECIM = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [11:0] y_in = '0;
    logic        ovf_clr = 1'b0;
    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  level;
    logic        ovf;

    int checks = 0;
    int failures = 0;

    logic [11:0] win[$];
    logic [11:0] mq[$];
    bit          movf = 1'b0;

    iir_decim #(.DECIM(DECIM), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .y_in      (y_in),
        .ovf_clr   (ovf_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'(mq.size() > 0));
        chk({tag, "_level"}, 32'(level), 32'(mq.size()));
        chk({tag, "_ovf"}, 32'(ovf), 32'(movf));
        if (mq.size() > 0) chk({tag, "_data"}, 32'(out_data), 32'(mq[0]));
    endtask

    // One clock: drive inputs, advance the model across the edge, compare.
    task automatic step(input bit e, input logic [11:0] y, input bit rdy, input bit clr);
        bit          pop;
        bit          have;
        logic [11:0] res;
        int          s;
        en = e; y_in = y; out_ready = rdy; ovf_clr = clr;
        pop  = rdy && (mq.size() > 0);
        have = 1'b0;
        res  = '0;
        if (e) begin
            win.push_back(y);
            if (win.size() == DECIM) begin
                s = 0;
                foreach (win[i]) s += int'(win[i]);
                res  = 12'(s / DECIM);
                have = 1'b1;
                win.delete();
            end
        end
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (have && mq.size() >= DEPTH) movf = 1'b1;
        else begin
            if (have) mq.push_back(res);
            if (clr) movf = 1'b0;
        end
        #1;
        chk_model("step");
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (mq.size() > 0) step(1'b0, 12'd0, 1'b1, 1'b0);
        end
        chk("drained_level", 32'(level), 32'd0);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1; en = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        chk("rst_async_level", 32'(level), 32'd0);
        chk("rst_async_ovf", 32'(ovf), 32'd0);
        chk("rst_async_data", 32'(out_data), 32'd0);
        @(posedge clk); #1;
        chk("rst_hold_level", 32'(level), 32'd0);
        chk("rst_hold_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        win.delete(); mq.delete(); movf = 1'b0;
        repeat (3) step(1'b0, 12'd0, 1'b0, 1'b0);
    endtask

    initial begin
        // Power-on reset
        #1;
        chk("por_valid", 32'(out_valid), 32'd0);
        chk("por_level", 32'(level), 32'd0);
        do_reset();

        // Constant input: average equals the input
        repeat (4) step(1'b1, 12'd100, 1'b0, 1'b0);
        chk("const_valid", 32'(out_valid), 32'd1);
        chk("const_data", 32'(out_data), 32'd100);
        chk("const_level", 32'(level), 32'd1);
        drain();

        // Ramp 0..7 with consumer ready
        for (int i = 0; i < 4; i++) step(1'b1, 12'(i), 1'b1, 1'b0);
        chk("ramp_first", 32'(out_data), 32'd1);
        for (int i = 4; i < 8; i++) step(1'b1, 12'(i), 1'b1, 1'b0);
        chk("ramp_second", 32'(out_data), 32'd5);
        chk("ramp_level", 32'(level), 32'd1);
        drain();

        // Overflow: nine results into an eight-deep FIFO
        for (int i = 0; i < 9 * DECIM; i++) step(1'b1, 12'($urandom_range(0, 4095)), 1'b0, 1'b0);
        chk("ovf_level", 32'(level), 32'd8);
        chk("ovf_set", 32'(ovf), 32'd1);
        step(1'b0, 12'd0, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(ovf), 32'd0);
        chk("ovf_keep_level", 32'(level), 32'd8);
        drain();

        // Full FIFO with simultaneous pop and push
        for (int i = 0; i < 8 * DECIM + 3; i++) step(1'b1, 12'($urandom_range(0, 4095)), 1'b0, 1'b0);
        step(1'b1, 12'($urandom_range(0, 4095)), 1'b1, 1'b0);
        chk("popush_level", 32'(level), 32'd8);
        chk("popush_ovf", 32'(ovf), 32'd0);
        drain();

        // Drop and clear on the same edge: set wins
        for (int i = 0; i < 8 * DECIM + 3; i++) step(1'b1, 12'($urandom_range(0, 4095)), 1'b0, 1'b0);
        step(1'b1, 12'd7, 1'b0, 1'b1);
        chk("setwins_ovf", 32'(ovf), 32'd1);
        step(1'b0, 12'd0, 1'b0, 1'b1);
        drain();

        // en gaps: bubbles ignored
        step(1'b1, 12'd4, 1'b0, 1'b0);
        step(1'b0, 12'd99, 1'b0, 1'b0);
        step(1'b1, 12'd8, 1'b0, 1'b0);
        step(1'b0, 12'd99, 1'b0, 1'b0);
        step(1'b1, 12'd12, 1'b0, 1'b0);
        step(1'b0, 12'd99, 1'b0, 1'b0);
        step(1'b1, 12'd16, 1'b0, 1'b0);
        chk("gaps_data", 32'(out_data), 32'd10);
        drain();

        // Reset mid-accumulation discards the partial sum
        step(1'b1, 12'd400, 1'b0, 1'b0);
        step(1'b1, 12'd400, 1'b0, 1'b0);
        do_reset();
        repeat (4) step(1'b1, 12'd20, 1'b0, 1'b0);
        chk("midrst_data", 32'(out_data), 32'd20);
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 3) != 0), 12'($urandom_range(0, 4095)),
                 bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 15) == 0));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/iir_decim.md
IIR_DECIM -- requirements
Module: iir_decim

Interface
REQ-001 Parameter DECIM, default 4, SHALL set the decimation ratio; it SHALL be a power of two in 2..16.
REQ-002 Parameter DEPTH, default 8, SHALL set the output FIFO depth in entries; it SHALL be a power of two in 2..16.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  y_in carries a valid filter output sample this cycle.
REQ-006 y_in  input  12  unsigned filter output sample, the 12-bit y of the upstream IIR stage.
REQ-007 ovf_clr  input  1  clears the sticky overflow flag.
REQ-008 out_data  output  12  decimated sample at the FIFO head.
REQ-009 out_valid  output  1  the FIFO is non-empty and out_data is valid.
REQ-010 out_ready  input  1  the consumer accepts out_data when this and out_valid are both high.
REQ-011 level  output  clog2(DEPTH+1)  current FIFO occupancy, 0..DEPTH.
REQ-012 ovf  output  1  sticky flag: at least one decimated result has been dropped.

Function
REQ-013 The block SHALL accept one sample per clk edge where en=1 and SHALL ignore y_in when en=0, leaving all accumulation state unchanged.
REQ-014 The accumulator SHALL be 12+log2(DECIM) bits wide, unsigned, so it SHALL never overflow.
REQ-015 The phase counter SHALL count accepted samples 0..DECIM-1 and SHALL wrap to 0 after DECIM-1.
REQ-016 On the edge that accepts the sample at phase DECIM-1, the result SHALL be (acc + y_in) >> log2(DECIM), truncated, 12 bits.
REQ-017 On that same edge the accumulator SHALL reload to 0, so no sample contributes to two results.
REQ-018 Each result SHALL be pushed into the FIFO on the same edge it is computed.
REQ-019 out_valid SHALL rise in the cycle after the push when the FIFO was empty, giving a latency of one cycle from the DECIMth sample edge.
REQ-020 The FIFO SHALL be first-word-fall-through: out_data SHALL show the oldest entry whenever out_valid=1.
REQ-021 out_data SHALL hold its value while out_valid=1 and out_ready=0.
REQ-022 A pop SHALL occur on an edge with out_valid=1 and out_ready=1.
REQ-023 out_ready while out_valid=0 SHALL have no effect.
REQ-024 A push SHALL be accepted if level<DEPTH, or if level=DEPTH and a pop occurs on the same edge.
REQ-025 In the full-with-pop case, level SHALL remain DEPTH and order SHALL be preserved.
REQ-026 A push that is not accepted SHALL be dropped, leaving FIFO contents and level unchanged, and SHALL set ovf=1.
REQ-027 ovf SHALL stay 1 until an edge with ovf_clr=1.
REQ-028 If ovf_clr=1 and a drop occur on the same edge, ovf SHALL be 1 after the edge (set wins).
REQ-029 level SHALL change by +1 on push-only, -1 on pop-only and 0 on push+pop or on no operation.
REQ-030 The read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-031 While rst=1, independent of clk: accumulator=0, phase=0, FIFO pointers=0, level=0, out_valid=0, ovf=0, out_data=0.
REQ-032 A reset mid-accumulation SHALL discard the partial sum; the first result after reset SHALL use the next DECIM accepted samples only.
REQ-033 Reset deassertion SHALL be synchronised to clk before use; the first en sample SHALL be taken no earlier than the second edge after rst falls.

Structure
REQ-034 The shared package iir_pkg SHALL hold Y_W=12 and the default DECIM and DEPTH constants, for use by the upstream filter and by this block.
REQ-035 The FIFO SHALL be one sub-module, iir_fifo (parameters W, DEPTH), providing push, pop, full, empty and level; decimation logic SHALL stay in iir_decim.

Verification
REQ-036 With DECIM=4, y_in=100 held and en=1 for 4 cycles: out_valid=1 one cycle after the 4th edge, out_data=100, level=1.
REQ-037 Ramp y_in=0..7 with en=1 and out_ready=1: outputs 1 (6>>2) then 5 (22>>2), in order.
REQ-038 out_ready=0 and 9 decimation periods (DEPTH=8): level=8, the 9th result is dropped and ovf=1; after ovf_clr, ovf=0 and contents are unchanged.
REQ-039 FIFO full and out_ready=1 on the edge a result is pushed: pop and push both succeed, level stays 8, ovf stays 0, order is preserved.
REQ-040 en toggling 1,0,1,0 with values 4,99,8,99,12,99,16: the 99s are ignored and the result is 10.
REQ-041 rst pulse after 2 of 4 samples (values 400,400), then 4 samples of 20: the first output is 20; level=0 and out_valid=0 during reset.
